// File: rtl/exibe_sequencia_pkg.sv
// rtl/exibe_sequencia_pkg.sv - state codes and default timing for the sequence replay block
package exibe_sequencia_pkg;

  localparam logic [3:0] ESTADO_OCIOSO  = 4'd0;
  localparam logic [3:0] ESTADO_CARREGA = 4'd1;
  localparam logic [3:0] ESTADO_ESPERA  = 4'd2;
  localparam logic [3:0] ESTADO_ACENDE  = 4'd3;
  localparam logic [3:0] ESTADO_APAGA   = 4'd4;
  localparam logic [3:0] ESTADO_FIM     = 4'd5;

  localparam int T_ACESO_PADRAO   = 1000;
  localparam int T_APAGADO_PADRAO = 500;

  typedef enum logic [3:0] {
    OCIOSO  = ESTADO_OCIOSO,
    CARREGA = ESTADO_CARREGA,
    ESPERA  = ESTADO_ESPERA,
    ACENDE  = ESTADO_ACENDE,
    APAGA   = ESTADO_APAGA,
    FIM     = ESTADO_FIM
  } estado_t;

  // Timer must hold the largest terminal count; both phases share one counter.
  function automatic int largura_timer(input int t_aceso, input int t_apagado);
    int maior;
    maior = (t_aceso > t_apagado) ? t_aceso : t_apagado;
    return $clog2(maior + 1);
  endfunction

endpackage

// File: rtl/exibe_sequencia_temporizador_exibicao.sv
// rtl/exibe_sequencia_temporizador_exibicao.sv - phase timer with clear/count and terminal flag
module temporizador_exibicao
  import exibe_sequencia_pkg::*;
#(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  input  logic [W-1:0] limite_tempo,
  output logic         fim
);

  logic [W-1:0] valor;

  // Clear wins over count so the FSM can restart the phase on the terminal cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor <= '0;
    end else if (zera) begin
      valor <= '0;
    end else if (conta) begin
      valor <= valor + 1'b1;
    end
  end

  assign fim = (valor == limite_tempo);

endmodule

// File: rtl/exibe_sequencia.sv
// rtl/exibe_sequencia.sv - replays stored moves 0..limite on the leds, then pulses pronto
module exibe_sequencia
  import exibe_sequencia_pkg::*;
#(
  parameter int T_ACESO   = T_ACESO_PADRAO,
  parameter int T_APAGADO = T_APAGADO_PADRAO,
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              cancelar,
  input  logic [ADDR_W-1:0] limite,
  input  logic [DATA_W-1:0] dado_memoria,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] leds,
  output logic              ativo,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  localparam int TW = largura_timer(T_ACESO, T_APAGADO);
  localparam logic [TW-1:0] FIM_ACESO   = TW'(T_ACESO - 1);
  localparam logic [TW-1:0] FIM_APAGADO = TW'(T_APAGADO - 1);

  estado_t           estado;
  estado_t           estado_prox;
  logic [ADDR_W-1:0] lim;

  logic          zera_tempo;
  logic          conta_tempo;
  logic          fim_tempo;
  logic [TW-1:0] limite_tempo;

  logic carrega_lim;
  logic zera_end;
  logic inc_end;
  logic carrega_leds;
  logic apaga_leds;

  temporizador_exibicao #(
    .W(TW)
  ) u_temporizador (
    .clock        (clock),
    .reset        (reset),
    .zera         (zera_tempo),
    .conta        (conta_tempo),
    .limite_tempo (limite_tempo),
    .fim          (fim_tempo)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_prox;
    end
  end

  always_comb begin
    estado_prox  = estado;
    zera_tempo   = 1'b1;
    conta_tempo  = 1'b0;
    limite_tempo = FIM_ACESO;
    carrega_lim  = 1'b0;
    zera_end     = 1'b0;
    inc_end      = 1'b0;
    carrega_leds = 1'b0;
    apaga_leds   = 1'b0;

    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          carrega_lim = 1'b1;
          zera_end    = 1'b1;
          estado_prox = CARREGA;
        end
      end
      CARREGA: estado_prox = ESPERA;
      ESPERA: begin
        carrega_leds = 1'b1;
        estado_prox  = ACENDE;
      end
      ACENDE: begin
        zera_tempo  = 1'b0;
        conta_tempo = 1'b1;
        if (fim_tempo) begin
          zera_tempo  = 1'b1;
          apaga_leds  = 1'b1;
          estado_prox = APAGA;
        end
      end
      APAGA: begin
        limite_tempo = FIM_APAGADO;
        zera_tempo   = 1'b0;
        conta_tempo  = 1'b1;
        if (fim_tempo) begin
          zera_tempo = 1'b1;
          // Stop test precedes the increment so endereco never wraps past lim.
          if (endereco == lim) begin
            estado_prox = FIM;
          end else begin
            inc_end     = 1'b1;
            estado_prox = CARREGA;
          end
        end
      end
      FIM:     estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase

    if (cancelar && (estado != OCIOSO)) begin
      estado_prox  = OCIOSO;
      zera_tempo   = 1'b1;
      conta_tempo  = 1'b0;
      zera_end     = 1'b1;
      inc_end      = 1'b0;
      carrega_leds = 1'b0;
      apaga_leds   = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lim <= '0;
    end else if (carrega_lim) begin
      lim <= limite;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endereco <= '0;
    end else if (zera_end) begin
      endereco <= '0;
    end else if (inc_end) begin
      endereco <= endereco + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      leds <= '0;
    end else if (apaga_leds) begin
      leds <= '0;
    end else if (carrega_leds) begin
      leds <= dado_memoria;
    end
  end

  assign ativo     = (estado == CARREGA) || (estado == ESPERA) ||
                     (estado == ACENDE)  || (estado == APAGA);
  assign pronto    = (estado == FIM);
  assign db_estado = estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// tb/tb_exibe_sequencia.sv - scoreboard bench for exibe_sequencia
module tb_exibe_sequencia;

  localparam int TA = 4;
  localparam int TP = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       cancelar = 1'b0;
  logic [3:0] limite = 4'd0;
  logic [3:0] dado_memoria;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ativo;
  logic       pronto;
  logic [3:0] db_estado;

  logic [3:0]  mem [16];
  logic [15:0] fila [$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clock = ~clock;

  always @(posedge clock) dado_memoria <= mem[endereco];

  exibe_sequencia #(
    .T_ACESO   (TA),
    .T_APAGADO (TP),
    .ADDR_W    (4),
    .DATA_W    (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .cancelar     (cancelar),
    .limite       (limite),
    .dado_memoria (dado_memoria),
    .endereco     (endereco),
    .leds         (leds),
    .ativo        (ativo),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  function automatic logic [15:0] pk(input logic [3:0] est, input logic [3:0] en,
                                     input logic [3:0] ld, input logic at, input logic pr);
    return {est, en, ld, at, pr, 2'b00};
  endfunction

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_vec++;
    if (obs !== esp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, esp);
    end
  endtask

  // Pops one expected tuple per cycle; inputs are adjusted after each sample.
  task automatic compara_fila(input string tag, input bit hold, input int cancel_at,
                              input int chg_at, input logic [3:0] chg_val);
    int c;
    logic [15:0] esp;
    c = 0;
    while (fila.size() > 0) begin
      @(negedge clock);
      c++;
      esp = fila.pop_front();
      confere($sformatf("%s c%0d", tag, c), {16'd0, pk(db_estado, endereco, leds, ativo, pronto)},
              {16'd0, esp});
      if (c == 1 && !hold) iniciar = 1'b0;
      if (c == chg_at) limite = chg_val;
      cancelar = (c == cancel_at);
    end
    cancelar = 1'b0;
  endtask

  task automatic replay(input string tag, input int lim, input bit hold, input int cancel_at,
                        input int chg_at, input logic [3:0] chg_val);
    logic [15:0] lixo;
    logic [3:0]  k4;
    for (int k = 0; k <= lim; k++) begin
      k4 = 4'(k);
      fila.push_back(pk(4'd1, k4, 4'd0, 1'b1, 1'b0));
      fila.push_back(pk(4'd2, k4, 4'd0, 1'b1, 1'b0));
      for (int j = 0; j < TA; j++) fila.push_back(pk(4'd3, k4, mem[k], 1'b1, 1'b0));
      for (int j = 0; j < TP; j++) fila.push_back(pk(4'd4, k4, 4'd0, 1'b1, 1'b0));
    end
    fila.push_back(pk(4'd5, 4'(lim), 4'd0, 1'b0, 1'b1));
    fila.push_back(pk(4'd0, 4'(lim), 4'd0, 1'b0, 1'b0));
    if (cancel_at > 0) begin
      while (fila.size() > cancel_at) lixo = fila.pop_back();
      for (int j = 0; j < 20; j++) fila.push_back(pk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
    end
    limite  = 4'(lim);
    iniciar = 1'b1;
    compara_fila(tag, hold, cancel_at, chg_at, chg_val);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));

    // Reset held: iniciar toggling must have no effect.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      iniciar = ~iniciar;
      fila.push_back(pk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
      confere($sformatf("reset c%0d", i), {16'd0, pk(db_estado, endereco, leds, ativo, pronto)},
              {16'd0, fila.pop_front()});
    end
    iniciar = 1'b0;
    reset   = 1'b0;
    for (int i = 0; i < 3; i++) fila.push_back(pk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
    compara_fila("pos_reset", 1'b1, 0, 0, 4'd0);

    replay("lim2", 2, 1'b0, 0, 0, 4'd0);
    replay("lim0", 0, 1'b0, 0, 0, 4'd0);
    replay("lim15", 15, 1'b0, 0, 0, 4'd0);

    // Cancel inside the second acende (entry 1 lit on cycles 11..14).
    replay("cancel", 3, 1'b0, 12, 0, 4'd0);

    // iniciar held with a mid-replay limite change, then back-to-back replays.
    replay("hold_a", 1, 1'b1, 0, 5, 4'd3);
    replay("hold_b", 1, 1'b1, 0, 0, 4'd0);
    replay("hold_c", 2, 1'b0, 0, 0, 4'd0);

    // Zero-valued entry shows dark with unchanged timing.
    mem[1] = 4'd0;
    replay("zero", 2, 1'b0, 0, 0, 4'd0);
    mem[1] = 4'd2;

    // Async reset between edges while lit.
    limite  = 4'd2;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    repeat (3) @(negedge clock);
    confere("pre_reset leds", {28'd0, leds}, 32'd1);
    #2 reset = 1'b1;
    #1 confere("async_reset", {16'd0, pk(db_estado, endereco, leds, ativo, pronto)}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) fila.push_back(pk(4'd0, 4'd0, 4'd0, 1'b0, 1'b0));
    compara_fila("apos_async", 1'b1, 0, 0, 4'd0);

    replay("final", 1, 1'b0, 0, 0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
